// File: rtl/wb_csr_bank_if.sv
// Wishbone classic slave bundle for wb_csr_bank.
// wbs_err_o exists only when WB_CSR_ERR_EN is defined.
interface wb_csr_bank_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
`ifdef WB_CSR_ERR_EN
    logic        wbs_err_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o, wbs_err_o
    );
    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o, wbs_err_o
    );
`else
    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
`endif
endinterface

// File: rtl/wb_csr_bank.sv
// Wishbone CSR bank: NUM_RW byte-lane-writable registers followed by NUM_RO live status words.
// Optional WB_CSR_ERR_EN turns unmapped accesses and status-register writes into wbs_err_o pulses.
module wb_csr_bank #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NUM_RW    = 4,
    parameter int          NUM_RO    = 2,
    parameter logic [31:0] RW_RST    = 32'h0000_0000
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    wb_csr_bank_if.slave          wbs,
    output logic [32*NUM_RW-1:0]  csr_rw_o,
    output logic [NUM_RW-1:0]     csr_wr_o,
    input  logic [32*NUM_RO-1:0]  csr_ro_i
);
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e                  state_q;
    logic [NUM_RW-1:0][31:0] rw_q;
    logic [NUM_RW-1:0]       wr_q;
    logic                    ack_q;
    logic [31:0]             dat_q;
`ifdef WB_CSR_ERR_EN
    logic                    err_q;
    logic                    err_s;
`endif

    logic [31:0]             offset_s;
    logic [29:0]             word_s;
    logic                    aligned_s;
    logic                    req_s;
    logic [31:0]             lane_mask_s;
    logic [31:0]             rd_data_s;
    logic [NUM_RW-1:0]       rw_hit_s;
    logic [NUM_RO-1:0]       ro_hit_s;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // Addresses below BASE_ADDR wrap to huge offsets and so never decode.
    assign offset_s    = wbs.wbs_adr_i - BASE_ADDR;
    assign word_s      = offset_s[31:2];
    assign aligned_s   = (offset_s[1:0] == 2'b00);
    assign req_s       = wbs.wbs_stb_i & wbs.wbs_cyc_i;
    assign lane_mask_s = lane_mask(wbs.wbs_sel_i);

    // Address decode and OR-based read mux; at most one hit bit is set.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        rw_hit_s  = {NUM_RW{1'b0}};
        ro_hit_s  = {NUM_RO{1'b0}};
        for (int i = 0; i < NUM_RW; i++) begin
            rw_hit_s[i] = aligned_s && (word_s == 30'(i));
            rd_data_s   = rd_data_s | ({32{rw_hit_s[i]}} & rw_q[i]);
        end
        for (int j = 0; j < NUM_RO; j++) begin
            ro_hit_s[j] = aligned_s && (word_s == 30'(NUM_RW + j));
            rd_data_s   = rd_data_s | ({32{ro_hit_s[j]}} & csr_ro_i[32*j +: 32]);
        end
    end

`ifdef WB_CSR_ERR_EN
    assign err_s = ~(|rw_hit_s) & (wbs.wbs_we_i | ~(|ro_hit_s));
`endif

    // Bus FSM: commits writes and registers every response output at the accepting edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0000_0000;
            wr_q    <= {NUM_RW{1'b0}};
            for (int i = 0; i < NUM_RW; i++) begin
                rw_q[i] <= RW_RST;
            end
`ifdef WB_CSR_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s) begin
                        state_q <= ST_RESP;
                        dat_q   <= wbs.wbs_we_i ? 32'h0000_0000 : (rd_data_s & lane_mask_s);
                        wr_q    <= wbs.wbs_we_i ? rw_hit_s : {NUM_RW{1'b0}};
                        for (int i = 0; i < NUM_RW; i++) begin
                            if (wbs.wbs_we_i && rw_hit_s[i]) begin
                                rw_q[i] <= merge_lanes(rw_q[i], wbs.wbs_dat_i, lane_mask_s);
                            end else begin
                                rw_q[i] <= rw_q[i];
                            end
                        end
`ifdef WB_CSR_ERR_EN
                        ack_q   <= ~err_s;
                        err_q   <= err_s;
`else
                        ack_q   <= 1'b1;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                        ack_q   <= 1'b0;
                        wr_q    <= {NUM_RW{1'b0}};
`ifdef WB_CSR_ERR_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    wr_q    <= {NUM_RW{1'b0}};
`ifdef WB_CSR_ERR_EN
                    err_q   <= 1'b0;
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    wr_q    <= {NUM_RW{1'b0}};
`ifdef WB_CSR_ERR_EN
                    err_q   <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
`ifdef WB_CSR_ERR_EN
    assign wbs.wbs_err_o = err_q;
`endif
    assign csr_rw_o      = rw_q;
    assign csr_wr_o      = wr_q;
endmodule
